// File: rtl/wheel_speed_ctrl_pkg.sv
// robot_pkg: shared types and constants for the wheel speed controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state encoding, speed/measurement widths, duty ceiling,
//           saturating edge-count increment helper.
package robot_pkg;

  typedef enum logic [1:0] {
    ST_STOP   = 2'd0,
    ST_RUN    = 2'd1,
    ST_UPDATE = 2'd2
  } state_e;

  localparam int SPEED_W = 5;  // target speed width (edges per window)
  localparam int MEAS_W  = 6;  // measured speed width, saturates at 63

  function automatic int duty_max(input int bits);
    return (1 << bits) - 1;
  endfunction

  localparam int DUTY_MAX = duty_max(8);

  // Add a single edge to a count, sticking at all-ones.
  function automatic logic [MEAS_W-1:0] sat_inc(input logic [MEAS_W-1:0] v,
                                                input logic inc);
    return (inc && (v != {MEAS_W{1'b1}})) ? v + 1'b1 : v;
  endfunction

endpackage

// File: rtl/wheel_speed_ctrl_pwm_gen.sv
// pwm_gen: free-running PWM counter with period-boundary duty reload.
// Latency: new duty_i takes effect at the period after the counter wraps; pwm_o registered.
// Backpressure: none; clear_i zeroes the active duty on the next edge.
// Ports: clk_i/rst_i clock and async active-high reset, clear_i forced stop,
//        duty_i commanded duty, pwm_o motor drive.
module pwm_gen #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clear_i,
  input  logic [PWM_BITS-1:0] duty_i,
  output logic                pwm_o
);

  logic [PWM_BITS-1:0] cnt_q;
  logic [PWM_BITS-1:0] active_q;
  logic                pwm_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      active_q <= '0;
      pwm_q    <= 1'b0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
      // Reload only as the counter wraps so each period uses a single duty.
      if (clear_i) begin
        active_q <= '0;
      end else if (cnt_q == {PWM_BITS{1'b1}}) begin
        active_q <= duty_i;
      end
      pwm_q <= (cnt_q < active_q);
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/wheel_speed_ctrl.sv
// wheel_speed_ctrl: closed-loop wheel speed controller (encoder count -> PWM duty).
// Latency: encoder edge counted 4 cycles after encdr rises; duty updates once per window.
// Backpressure: none; enable low stops the motor on the next edge.
// Ports: WF_CLK clock, reset async active-high, enable motor enable, encdr raw
//        encoder, target edges/window; pwm drive, duty commanded duty,
//        meas_speed last window count, sample_tick one-cycle update marker.
module wheel_speed_ctrl
  import robot_pkg::*;
#(
  parameter int SAMPLE_CYCLES = 160000,
  parameter int GAIN_SHIFT    = 2,
  parameter int PWM_BITS      = 8
) (
  input  logic                WF_CLK,
  input  logic                reset,
  input  logic                enable,
  input  logic                encdr,
  input  logic [SPEED_W-1:0]  target,
  output logic                pwm,
  output logic [PWM_BITS-1:0] duty,
  output logic [MEAS_W-1:0]   meas_speed,
  output logic                sample_tick
);

  localparam int WIN_W  = $clog2(SAMPLE_CYCLES);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(SAMPLE_CYCLES - 1);
  // Wide enough for duty plus a shifted 7-bit signed error without overflow.
  localparam int CALC_W = PWM_BITS + GAIN_SHIFT + 8;
  localparam logic signed [CALC_W-1:0] DMAX_S = CALC_W'(duty_max(PWM_BITS));

  // Encoder synchronizer and 3-sample glitch filter.
  logic       sync1_q, sync2_q;
  logic [1:0] hist_q;
  logic       filt_q, filt_d;
  logic       edge_rise;

  always_comb begin
    filt_d = filt_q;
    if ((sync2_q == hist_q[0]) && (sync2_q == hist_q[1])) begin
      filt_d = sync2_q;
    end
    edge_rise = filt_d & ~filt_q;
  end

  always_ff @(posedge WF_CLK or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= '0;
      filt_q  <= 1'b0;
    end else begin
      sync1_q <= encdr;
      sync2_q <= sync1_q;
      hist_q  <= {hist_q[0], sync2_q};
      filt_q  <= filt_d;
    end
  end

  // Control loop state.
  state_e              state_q, state_d;
  logic [WIN_W-1:0]    win_q, win_d;
  logic [MEAS_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic [MEAS_W-1:0]   meas_q, meas_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [PWM_BITS-1:0] duty_upd;

  // Proportional update: duty + (target - meas) << GAIN_SHIFT, clamped.
  always_comb begin
    logic signed [6:0]        err;
    logic signed [CALC_W-1:0] sum;
    err = $signed({2'b00, target}) - $signed({1'b0, meas_q});
    sum = $signed({{(CALC_W-PWM_BITS){1'b0}}, duty_q})
        + ($signed({{(CALC_W-7){err[6]}}, err}) <<< GAIN_SHIFT);
    duty_upd = '0;
    if (target == '0) begin
      duty_upd = '0;
    end else if (sum < 0) begin
      duty_upd = '0;
    end else if (sum > DMAX_S) begin
      duty_upd = {PWM_BITS{1'b1}};
    end else begin
      duty_upd = sum[PWM_BITS-1:0];
    end
  end

  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    edge_cnt_d = edge_cnt_q;
    meas_d     = meas_q;
    duty_d     = duty_q;
    case (state_q)
      ST_STOP: begin
        win_d      = '0;
        edge_cnt_d = '0;
        duty_d     = '0;
        if (enable) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (win_q == WIN_LAST) begin
          // An edge landing on the last cycle still belongs to this window.
          meas_d     = sat_inc(edge_cnt_q, edge_rise);
          edge_cnt_d = '0;
          win_d      = '0;
          state_d    = ST_UPDATE;
        end else begin
          win_d      = win_q + 1'b1;
          edge_cnt_d = sat_inc(edge_cnt_q, edge_rise);
        end
      end
      ST_UPDATE: begin
        // The new window is already running; keep counting through here.
        win_d      = win_q + 1'b1;
        edge_cnt_d = sat_inc(edge_cnt_q, edge_rise);
        duty_d     = duty_upd;
        state_d    = ST_RUN;
      end
      default: state_d = ST_STOP;
    endcase
    if (!enable) begin
      state_d = ST_STOP;
      duty_d  = '0;
    end
  end

  always_ff @(posedge WF_CLK or posedge reset) begin
    if (reset) begin
      state_q    <= ST_STOP;
      win_q      <= '0;
      edge_cnt_q <= '0;
      meas_q     <= '0;
      duty_q     <= '0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      edge_cnt_q <= edge_cnt_d;
      meas_q     <= meas_d;
      duty_q     <= duty_d;
    end
  end

  assign sample_tick = (state_q == ST_UPDATE);
  assign duty        = duty_q;
  assign meas_speed  = meas_q;

  pwm_gen #(
    .PWM_BITS(PWM_BITS)
  ) u_pwm_gen (
    .clk_i  (WF_CLK),
    .rst_i  (reset),
    .clear_i(~enable),
    .duty_i (duty_q),
    .pwm_o  (pwm)
  );

endmodule

// File: tb/tb_wheel_speed_ctrl.sv
// Testbench for wheel_speed_ctrl: directed scenarios with hand-computed expectations.
module tb_wheel_speed_ctrl;
  import robot_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, enc = 1'b0;
  logic [4:0] tgt = '0;
  logic       pwm, tick;
  logic [7:0] duty;
  logic [5:0] meas;

  logic       en2 = 1'b0, enc2 = 1'b0;
  logic [4:0] tgt2 = '0;
  logic       pwm2, tick2;
  logic [7:0] duty2;
  logic [5:0] meas2;

  int checks = 0;
  int failures = 0;

  // Bench time base matching a free-running 8-bit counter cleared by reset.
  logic [7:0] m_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) m_cnt <= '0;
    else     m_cnt <= m_cnt + 8'd1;
  end

  always #5 clk = ~clk;

  wheel_speed_ctrl #(.SAMPLE_CYCLES(64), .GAIN_SHIFT(2), .PWM_BITS(8)) dut (
    .WF_CLK(clk), .reset(rst), .enable(en), .encdr(enc), .target(tgt),
    .pwm(pwm), .duty(duty), .meas_speed(meas), .sample_tick(tick)
  );

  // Long window so that 80 filtered edges fit inside one measurement.
  wheel_speed_ctrl #(.SAMPLE_CYCLES(1024), .GAIN_SHIFT(2), .PWM_BITS(8)) u_sat (
    .WF_CLK(clk), .reset(rst), .enable(en2), .encdr(enc2), .target(tgt2),
    .pwm(pwm2), .duty(duty2), .meas_speed(meas2), .sample_tick(tick2)
  );

  task automatic drive(input logic v, input int n, inout int cyc);
    enc = v;
    repeat (n) @(negedge clk);
    cyc += n;
  endtask

  task automatic wait_tick(input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tick !== 1'b1 && n < limit);
  endtask

  // Starts one cycle after an update; returns the window's measurement,
  // the duty after its update, and negedges to the tick (63 when aligned).
  task automatic do_window(input int npulses, input bit glitch, input logic [4:0] t,
                           output logic [5:0] m, output logic [7:0] d, output int cyc);
    cyc = 0;
    tgt = t;
    if (glitch) begin
      drive(1'b1, 1, cyc); drive(1'b0, 5, cyc);
      drive(1'b1, 2, cyc); drive(1'b0, 5, cyc);
      drive(1'b1, 4, cyc); drive(1'b0, 1, cyc);
      drive(1'b1, 4, cyc); drive(1'b0, 5, cyc);
    end else begin
      repeat (npulses) begin
        drive(1'b1, 4, cyc);
        drive(1'b0, 4, cyc);
      end
    end
    while (tick !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    m = meas;
    @(negedge clk);
    d = duty;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (pwm !== 1'b0) begin failures++; $display("FAIL reset_pwm: got %b want 0", pwm); end
    checks++; if (duty !== 8'd0) begin failures++; $display("FAIL reset_duty: got %0d want 0", duty); end
    checks++; if (meas !== 6'd0) begin failures++; $display("FAIL reset_meas: got %0d want 0", meas); end
    checks++; if (tick !== 1'b0) begin failures++; $display("FAIL reset_tick: got %b want 0", tick); end
  endtask

  task automatic test_target_zero();
    int n, t1, t2, bad;
    n = 0; t1 = 0; t2 = 0; bad = 0;
    rst = 1'b0; en = 1'b1; tgt = 5'd0;
    while (n < 200 && t2 == 0) begin
      @(negedge clk);
      n++;
      if (pwm !== 1'b0 || duty !== 8'd0) bad++;
      if (tick === 1'b1) begin
        if (t1 == 0) t1 = n;
        else         t2 = n;
      end
    end
    checks++; if (t1 != 65) begin failures++; $display("FAIL first_tick: at %0d want 65", t1); end
    checks++; if (t2 - t1 != 64) begin failures++; $display("FAIL tick_period: got %0d want 64", t2 - t1); end
    checks++; if (bad != 0) begin failures++; $display("FAIL idle_outputs: %0d nonzero cycles want 0", bad); end
    @(negedge clk);
  endtask

  task automatic test_gain();
    logic [5:0] m; logic [7:0] d; int c;
    for (int k = 1; k <= 3; k++) begin
      do_window(6, 1'b0, 5'd10, m, d, c);
      checks++; if (c != 63) begin failures++; $display("FAIL gain_win%0d: %0d cycles want 63", k, c); end
      checks++; if (m !== 6'd6) begin failures++; $display("FAIL gain_meas%0d: got %0d want 6", k, m); end
      checks++; if (d !== 8'(16 * k)) begin failures++; $display("FAIL gain_duty%0d: got %0d want %0d", k, d, 16 * k); end
    end
  endtask

  task automatic test_clamp();
    logic [5:0] m; logic [7:0] d; int c;
    int         np[8]  = '{0, 0, 0, 0, 0, 6, 0, 0};
    logic [4:0] tv[8]  = '{5'd31, 5'd31, 5'd31, 5'd0, 5'd1, 5'd1, 5'd1, 5'd0};
    int         exd[8] = '{172, DUTY_MAX, DUTY_MAX, 0, 4, 0, 4, 0};
    for (int k = 0; k < 8; k++) begin
      do_window(np[k], 1'b0, tv[k], m, d, c);
      checks++; if (c != 63) begin failures++; $display("FAIL clamp_win%0d: %0d cycles want 63", k, c); end
      checks++; if (d !== 8'(exd[k])) begin failures++; $display("FAIL clamp_duty%0d: got %0d want %0d", k, d, exd[k]); end
    end
  endtask

  task automatic test_glitch();
    logic [5:0] m; logic [7:0] d; int c;
    do_window(0, 1'b1, 5'd0, m, d, c);
    checks++; if (c != 63) begin failures++; $display("FAIL glitch_win: %0d cycles want 63", c); end
    checks++; if (m !== 6'd1) begin failures++; $display("FAIL glitch_meas: got %0d want 1", m); end
    checks++; if (d !== 8'd0) begin failures++; $display("FAIL glitch_duty: got %0d want 0", d); end
  endtask

  task automatic test_saturation();
    int n;
    en2 = 1'b1; tgt2 = 5'd31;
    @(negedge clk);
    n = 1;
    repeat (80) begin
      enc2 = 1'b1; repeat (4) @(negedge clk);
      enc2 = 1'b0; repeat (4) @(negedge clk);
      n += 8;
    end
    while (tick2 !== 1'b1 && n < 1200) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n != 1025) begin failures++; $display("FAIL sat_tick: at %0d want 1025", n); end
    checks++; if (meas2 !== 6'd63) begin failures++; $display("FAIL sat_meas: got %0d want 63", meas2); end
    @(negedge clk);
    checks++; if (duty2 !== 8'd0) begin failures++; $display("FAIL sat_duty: got %0d want 0", duty2); end
    en2 = 1'b0;
  endtask

  task automatic test_pwm_period();
    int n, highs, hold_bad, zero_bad;
    tgt = 5'd31;
    n = 0;
    while (duty !== 8'd255 && n < 400) begin @(negedge clk); n++; end
    checks++; if (duty !== 8'd255) begin failures++; $display("FAIL reach_255: got %0d want 255", duty); end
    n = 0;
    while (m_cnt != 8'd0 && n < 300) begin @(negedge clk); n++; end
    repeat (256) @(negedge clk);
    highs = 0;
    repeat (256) begin @(negedge clk); if (pwm === 1'b1) highs++; end
    checks++; if (highs != 255) begin failures++; $display("FAIL duty255_high: got %0d want 255", highs); end
    tgt = 5'd0;
    n = 0;
    while (duty !== 8'd0 && n < 100) begin @(negedge clk); n++; end
    checks++; if (duty !== 8'd0) begin failures++; $display("FAIL duty_drop: got %0d want 0", duty); end
    // The period in progress keeps the old duty; the next one is all low.
    if (m_cnt == 8'd0) @(negedge clk);
    hold_bad = 0; n = 0;
    while (m_cnt != 8'd0 && n < 300) begin
      if (pwm !== 1'b1) hold_bad++;
      @(negedge clk);
      n++;
    end
    zero_bad = 0;
    repeat (256) begin
      if (pwm !== 1'b0) zero_bad++;
      @(negedge clk);
    end
    checks++; if (hold_bad != 0) begin failures++; $display("FAIL pwm_hold_old: %0d low cycles want 0", hold_bad); end
    checks++; if (zero_bad != 0) begin failures++; $display("FAIL pwm_new_zero: %0d high cycles want 0", zero_bad); end
  endtask

  task automatic test_enable_drop();
    int n, bad;
    logic prev;
    tgt = 5'd8;
    n = 0;
    while (duty !== 8'd128 && n < 400) begin @(negedge clk); n++; end
    checks++; if (duty !== 8'd128) begin failures++; $display("FAIL reach_128: got %0d want 128", duty); end
    n = 0; prev = pwm;
    do begin prev = pwm; @(negedge clk); n++; end while (!(pwm === 1'b1 && prev === 1'b0) && n < 600);
    repeat (5) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    checks++; if (duty !== 8'd0) begin failures++; $display("FAIL drop_duty: got %0d want 0", duty); end
    checks++; if (pwm !== 1'b1) begin failures++; $display("FAIL drop_pwm1: got %b want 1", pwm); end
    @(negedge clk);
    checks++; if (pwm !== 1'b0) begin failures++; $display("FAIL drop_pwm2: got %b want 0", pwm); end
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (pwm !== 1'b0 || tick !== 1'b0 || duty !== 8'd0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL stopped_quiet: %0d active cycles want 0", bad); end
    en = 1'b1;
    wait_tick(200, n);
    checks++; if (n != 65) begin failures++; $display("FAIL reenable_tick: at %0d want 65", n); end
    @(negedge clk);
    checks++; if (duty !== 8'd32) begin failures++; $display("FAIL reenable_duty: got %0d want 32", duty); end
  endtask

  task automatic test_reset_mid();
    logic [5:0] m; logic [7:0] d; int c;
    do_window(6, 1'b0, 5'd10, m, d, c);
    checks++; if (m !== 6'd6 || d !== 8'd48) begin failures++; $display("FAIL pre_reset: meas %0d duty %0d want 6 48", m, d); end
    repeat (20) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (duty !== 8'd0) begin failures++; $display("FAIL midrst_duty: got %0d want 0", duty); end
    checks++; if (meas !== 6'd0) begin failures++; $display("FAIL midrst_meas: got %0d want 0", meas); end
    checks++; if (pwm !== 1'b0 || tick !== 1'b0) begin failures++; $display("FAIL midrst_pwm_tick: got %b %b want 0 0", pwm, tick); end
    @(negedge clk);
    rst = 1'b0;
    wait_tick(200, c);
    checks++; if (c != 65) begin failures++; $display("FAIL rst_restart_tick: at %0d want 65", c); end
    checks++; if (meas !== 6'd0) begin failures++; $display("FAIL rst_restart_meas: got %0d want 0", meas); end
    @(negedge clk);
    checks++; if (duty !== 8'd40) begin failures++; $display("FAIL rst_restart_duty: got %0d want 40", duty); end
  endtask

  initial begin
    test_reset();
    test_target_zero();
    test_gain();
    test_clamp();
    test_glitch();
    test_saturation();
    test_pwm_period();
    test_enable_drop();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wheel_speed_ctrl.md
WHEEL_SPEED_CTRL -- requirements
Module: wheel_speed_ctrl

Interface
REQ-001 Parameter SAMPLE_CYCLES, 160000, clock cycles per speed-measurement window (10 ms at 16 MHz); SHALL be >= 4.
REQ-002 Parameter GAIN_SHIFT, 2, left shift applied to speed error before adding to duty.
REQ-003 Parameter PWM_BITS, 8, PWM counter and duty width.
REQ-004 Port WF_CLK  in  1  sole clock, all state on rising edge.
REQ-005 Port reset  in  1  asynchronous, active-high reset.
REQ-006 Port enable  in  1  motor enable from command decoder; 0 forces motor stopped.
REQ-007 Port encdr  in  1  raw wheel encoder signal, asynchronous to WF_CLK.
REQ-008 Port target  in  5  target speed, encoder rising edges per window (0-31).
REQ-009 Port pwm  out  1  motor PWM drive.
REQ-010 Port duty  out  PWM_BITS  current commanded duty (0-255).
REQ-011 Port meas_speed  out  6  encoder rising edges counted in last completed window, saturating at 63.
REQ-012 Port sample_tick  out  1  one-cycle pulse marking each duty update.

Function
REQ-013 encdr SHALL pass a 2-flop synchronizer, then a 3-sample glitch filter: filtered level changes only after 3 consecutive equal synchronized samples.
REQ-014 A rising edge of the filtered level SHALL increment edge_cnt (6 bits), saturating at 63.
REQ-015 FSM states: STOP, RUN, UPDATE; reset state STOP.
REQ-016 STOP: window counter, edge_cnt, duty and active duty held at 0; enable=1 -> RUN next cycle with window counter at 0.
REQ-017 RUN: window counter increments each cycle; at SAMPLE_CYCLES-1: meas_speed <= saturating(edge_cnt + edge in that cycle), edge_cnt <= 0, window counter <= 0, go UPDATE.
REQ-018 Edges occurring during UPDATE SHALL count into the new window (window counter keeps running in UPDATE).
REQ-019 UPDATE (exactly one cycle): sample_tick=1; error = target - meas_speed (signed, 7 bits); duty <= clamp(duty + (error << GAIN_SHIFT), 0, 255) using >=11-bit signed arithmetic; target==0 forces duty <= 0; return to RUN.
REQ-020 enable=0 in any state SHALL go STOP next cycle and clear duty and active duty in that same edge, so pwm is low from the following cycle.
REQ-021 PWM: free-running PWM_BITS counter pwm_cnt; pwm = (pwm_cnt < active_duty), registered.
REQ-022 active_duty SHALL reload from duty only when pwm_cnt == 255 (glitch-free period boundary), except the REQ-020 forced clear.
REQ-023 duty=255 yields 255/256 high time; duty=0 yields pwm constantly low.
REQ-024 Latency: new duty visible on duty one cycle after sample_tick; on pwm from next PWM period start.

Reset
REQ-025 reset=1 SHALL asynchronously clear: FSM->STOP, pwm=0, duty=0, meas_speed=0, sample_tick=0, all counters, synchronizer and filter flops to 0.
REQ-026 Reset release mid-window SHALL restart measurement from window count 0; no partial window reported.

Structure
REQ-027 Package robot_pkg SHALL hold FSM state encoding, SPEED_W=5, MEAS_W=6, duty max constant.
REQ-028 PWM generation (counter, active-duty reload, compare) SHALL be sub-module pwm_gen.

Verification (SAMPLE_CYCLES=64 in bench)
REQ-029 Reset then enable=1, target=0, encoder idle -> duty=0, pwm=0 throughout, sample_tick every 64 cycles.
REQ-030 enable=1, target=10, encoder 6 edges/window -> each update duty increases by 16, meas_speed=6.
REQ-031 duty=250, target=31, meas=0 -> duty clamps at 255; duty=4, target=0 -> duty=0 next update.
REQ-032 encdr 1-cycle and 2-cycle glitches -> no count; 80 edges in window -> meas_speed=63.
REQ-033 enable dropped mid-PWM-high with duty=128 -> pwm low two cycles after enable falls, duty=0; re-enable restarts window at 0.
REQ-034 duty change mid-period -> pwm high-time changes only at period starting after pwm_cnt=255; reset asserted mid-window -> all outputs 0 immediately.
